// File: rtl/obi_req_arbiter.sv
// Round-robin arbiter sharing one OBI A-channel among NUM_REQ masters.
// Tracks outstanding owners in order and routes R-channel responses back.
module obi_req_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int ADDR_WIDTH      = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ-1:0]             we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  wdata_i,
  output logic [NUM_REQ-1:0]             gnt_o,
  output logic [NUM_REQ-1:0]             rvalid_o,
  output logic [DATA_WIDTH-1:0]          rdata_o,
  output logic                           cmd_valid_o,
  output logic                           cmd_we_o,
  output logic [ADDR_WIDTH-1:0]          cmd_addr_o,
  output logic [DATA_WIDTH-1:0]          cmd_wdata_o,
  input  logic                           cmd_ready_i,
  input  logic                           rsp_valid_i,
  input  logic [DATA_WIDTH-1:0]          rsp_rdata_i,
  output logic                           err_unexp_o
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int QW = (MAX_OUTSTANDING > 1) ?
                      $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] win;
  logic [PW-1:0] cand;
  logic          found;
  logic [PW-1:0] owner_q [MAX_OUTSTANDING];
  logic [QW-1:0] wr_ptr;
  logic [QW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          can_accept;
  logic          grant;
  logic          pop;
  logic [PW-1:0] head;
  logic [NUM_REQ-1:0] rsp_oh;

  function automatic logic [PW-1:0] rr_next(
    input logic [PW-1:0] p
  );
    return (int'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [QW-1:0] q_next(
    input logic [QW-1:0] p
  );
    return (int'(p) == MAX_OUTSTANDING - 1) ? '0 : p + 1'b1;
  endfunction

  // Search starts at rr_ptr and wraps, so the last winner goes last.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PW'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // A pop in this cycle does not free a slot for this cycle's grant.
  assign can_accept = cmd_ready_i &&
                      (count < CW'(MAX_OUTSTANDING));
  assign grant = found && can_accept && !rst;
  assign pop   = rsp_valid_i && (count != '0);
  assign head  = owner_q[rd_ptr];

  always_comb begin
    gnt_o = '0;
    if (grant) gnt_o[win] = 1'b1;
  end

  always_comb begin
    rsp_oh = '0;
    rsp_oh[head] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++)
        owner_q[i] <= '0;
      cmd_valid_o <= 1'b0;
      cmd_we_o    <= 1'b0;
      cmd_addr_o  <= '0;
      cmd_wdata_o <= '0;
      rvalid_o    <= '0;
      rdata_o     <= '0;
      err_unexp_o <= 1'b0;
    end else begin
      cmd_valid_o <= grant;
      if (grant) begin
        cmd_we_o   <= we_i[win];
        cmd_addr_o <=
          addr_i[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
        cmd_wdata_o <= we_i[win] ?
          wdata_i[int'(win)*DATA_WIDTH +: DATA_WIDTH] : '0;
        owner_q[wr_ptr] <= win;
        wr_ptr <= q_next(wr_ptr);
        rr_ptr <= rr_next(win);
      end
      if (pop) rd_ptr <= q_next(rd_ptr);
      unique case ({grant, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      rvalid_o <= pop ? rsp_oh : '0;
      if (pop) rdata_o <= rsp_rdata_i;
      err_unexp_o <= rsp_valid_i && (count == '0);
    end
  end

endmodule

// File: tb/tb_obi_req_arbiter.sv
// Self-checking bench for obi_req_arbiter: vector table plus
// hand-written sequences, with cmd/response scoreboard queues.
module tb_obi_req_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [1:0]  we = '0;
  logic [7:0]  addr = '0;
  logic [63:0] wdata = '0;
  logic        cmd_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_rdata = '0;

  logic [1:0]  gnt, rvalid;
  logic [31:0] rdata, cmd_wdata;
  logic        cmd_valid, cmd_we, err;
  logic [3:0]  cmd_addr;

  logic [1:0]  gnt4, rvalid4;
  logic [31:0] rdata4, cmd_wdata4;
  logic        cmd_valid4, cmd_we4, err4;
  logic [3:0]  cmd_addr4;

  obi_req_arbiter #(
    .NUM_REQ(2), .ADDR_WIDTH(4),
    .DATA_WIDTH(32), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt),
    .rvalid_o(rvalid), .rdata_o(rdata),
    .cmd_valid_o(cmd_valid), .cmd_we_o(cmd_we),
    .cmd_addr_o(cmd_addr), .cmd_wdata_o(cmd_wdata),
    .cmd_ready_i(cmd_ready), .rsp_valid_i(rsp_valid),
    .rsp_rdata_i(rsp_rdata), .err_unexp_o(err)
  );

  obi_req_arbiter #(
    .NUM_REQ(2), .ADDR_WIDTH(4),
    .DATA_WIDTH(32), .MAX_OUTSTANDING(4)
  ) dut4 (
    .clk(clk), .rst(rst), .req_i(req), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt4),
    .rvalid_o(rvalid4), .rdata_o(rdata4),
    .cmd_valid_o(cmd_valid4), .cmd_we_o(cmd_we4),
    .cmd_addr_o(cmd_addr4), .cmd_wdata_o(cmd_wdata4),
    .cmd_ready_i(cmd_ready), .rsp_valid_i(rsp_valid),
    .rsp_rdata_i(rsp_rdata), .err_unexp_o(err4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [3:0]  a0;
    logic [3:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        rdy;
    logic [1:0]  exp_gnt;
  } vec_t;

  typedef struct {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
  } cmd_t;

  cmd_t        cmd_q[$];
  int          own_q[$];
  logic [31:0] rdata_m;
  int          n_chk = 0;
  int          n_pass = 0;
  vec_t        vt[6];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " gnt"}, 64'(gnt), 64'd0);
    check({tag, " rvalid"}, 64'(rvalid), 64'd0);
    check({tag, " rdata"}, 64'(rdata), 64'd0);
    check({tag, " cmd_valid"}, 64'(cmd_valid), 64'd0);
    check({tag, " cmd_we"}, 64'(cmd_we), 64'd0);
    check({tag, " cmd_addr"}, 64'(cmd_addr), 64'd0);
    check({tag, " cmd_wdata"}, 64'(cmd_wdata), 64'd0);
    check({tag, " err"}, 64'(err), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    rsp_valid = 1'b0;
    cmd_q.delete();
    own_q.delete();
    rdata_m = '0;
    #1;
    check_zero(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One clock: check comb gnt, update models, check registered outputs.
  task automatic cycle(input logic [1:0] exp_gnt,
                       input string tag);
    logic [1:0]  exp_rv;
    logic [31:0] exp_rd;
    logic        exp_err;
    cmd_t        c;
    int          k;
    #1;
    check({tag, " gnt"}, 64'(gnt), 64'(exp_gnt));
    exp_rv  = '0;
    exp_err = 1'b0;
    exp_rd  = rdata_m;
    if (rsp_valid) begin
      if (own_q.size() > 0) begin
        exp_rv = 2'b01 << own_q.pop_front();
        exp_rd = rsp_rdata;
      end else begin
        exp_err = 1'b1;
      end
    end
    if (exp_gnt != 2'b00) begin
      k = exp_gnt[1] ? 1 : 0;
      own_q.push_back(k);
      c.we    = we[k];
      c.addr  = addr[k*4 +: 4];
      c.wdata = we[k] ? wdata[k*32 +: 32] : 32'd0;
      cmd_q.push_back(c);
    end
    @(posedge clk);
    #1;
    check({tag, " cmd_valid"}, 64'(cmd_valid),
          64'(exp_gnt != 2'b00));
    if (exp_gnt != 2'b00 && cmd_q.size() > 0) begin
      c = cmd_q.pop_front();
      check({tag, " cmd_we"}, 64'(cmd_we), 64'(c.we));
      check({tag, " cmd_addr"}, 64'(cmd_addr), 64'(c.addr));
      check({tag, " cmd_wdata"}, 64'(cmd_wdata),
            64'(c.wdata));
    end
    check({tag, " rvalid"}, 64'(rvalid), 64'(exp_rv));
    check({tag, " rdata"}, 64'(rdata), 64'(exp_rd));
    check({tag, " err"}, 64'(err), 64'(exp_err));
    rdata_m = exp_rd;
  endtask

  initial begin
    logic [1:0] e4[4];
    logic [1:0] e2[4];

    vt[0] = '{2'b01, 2'b01, 4'h3, 4'h0,
              32'hDEADBEEF, 32'h0, 1'b1, 2'b01};
    vt[1] = '{2'b10, 2'b00, 4'h1, 4'hA,
              32'h11111111, 32'h22222222, 1'b1, 2'b10};
    vt[2] = '{2'b11, 2'b00, 4'h5, 4'h6,
              32'h33333333, 32'h44444444, 1'b1, 2'b01};
    vt[3] = '{2'b11, 2'b11, 4'h7, 4'h8,
              32'h55555555, 32'h66666666, 1'b0, 2'b00};
    vt[4] = '{2'b00, 2'b11, 4'h9, 4'hB,
              32'h77777777, 32'h88888888, 1'b1, 2'b00};
    vt[5] = '{2'b10, 2'b10, 4'hC, 4'hF,
              32'h99999999, 32'hCAFEF00D, 1'b1, 2'b10};

    for (int i = 0; i < 6; i++) begin
      do_reset($sformatf("v%0d reset", i));
      req       = vt[i].req;
      we        = vt[i].we;
      addr      = {vt[i].a1, vt[i].a0};
      wdata     = {vt[i].d1, vt[i].d0};
      cmd_ready = vt[i].rdy;
      cycle(vt[i].exp_gnt, $sformatf("v%0d", i));
    end

    // Contention: depth 4 alternates, depth 2 saturates
    do_reset("cont reset");
    req = 2'b11; we = 2'b00; cmd_ready = 1'b1;
    e4 = '{2'b01, 2'b10, 2'b01, 2'b10};
    e2 = '{2'b01, 2'b10, 2'b00, 2'b00};
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("cont4 gnt%0d", i), 64'(gnt4),
            64'(e4[i]));
      check($sformatf("cont2 gnt%0d", i), 64'(gnt),
            64'(e2[i]));
      @(posedge clk);
      #1;
      check($sformatf("cont4 cmd_valid%0d", i),
            64'(cmd_valid4), 64'd1);
    end

    // Backpressure: full FIFO blocks, response frees next cycle
    do_reset("bp reset");
    we = 2'b00; addr = 8'h21; cmd_ready = 1'b1;
    req = 2'b01; cycle(2'b01, "bp g0");
    req = 2'b10; cycle(2'b10, "bp g1");
    req = 2'b11; cycle(2'b00, "bp full0");
    cycle(2'b00, "bp full1");
    rsp_valid = 1'b1; rsp_rdata = 32'h12345678;
    cycle(2'b00, "bp pop");
    rsp_valid = 1'b0;
    cycle(2'b01, "bp resume");
    req = 2'b00; rsp_valid = 1'b1; rsp_rdata = 32'h0BAD0001;
    cycle(2'b00, "bp drain0");
    rsp_rdata = 32'h0BAD0002;
    cycle(2'b00, "bp drain1");
    rsp_valid = 1'b0;

    // Routing: M1 then M0, responses in order
    do_reset("rt reset");
    we = 2'b00; addr = 8'h4C; cmd_ready = 1'b1;
    req = 2'b10; cycle(2'b10, "rt m1");
    req = 2'b01; cycle(2'b01, "rt m0");
    req = 2'b00; rsp_valid = 1'b1; rsp_rdata = 32'hAAAA;
    cycle(2'b00, "rt r1");
    rsp_rdata = 32'h5555;
    cycle(2'b00, "rt r0");
    rsp_valid = 1'b0;
    cycle(2'b00, "rt hold");

    // Unexpected response
    rsp_valid = 1'b1; rsp_rdata = 32'hFFFF0000;
    cycle(2'b00, "unexp");
    rsp_valid = 1'b0;
    cycle(2'b00, "unexp clr");

    // Reset with a read outstanding and requests pending
    we = 2'b00; addr = 8'h3E; cmd_ready = 1'b1;
    req = 2'b10; cycle(2'b10, "mid m1");
    req = 2'b11;
    do_reset("mid reset");
    req = 2'b00; rsp_valid = 1'b1; rsp_rdata = 32'h77;
    cycle(2'b00, "mid late rsp");
    rsp_valid = 1'b0; req = 2'b11;
    cycle(2'b01, "mid restart");
    req = 2'b00;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
